// File: rtl/hci_core_arb_sched.sv
// Round-robin arbiter with starvation override for requesters sharing one HCI
// initiator port; an in-order FIFO of winner indices routes responses back.

module hci_core_arb_sched_wait #(
    parameter int unsigned LIMIT = 8,
    parameter int unsigned WW    = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic req_i,
    input  logic gnt_i,
    output logic starve_o
);
    logic [WW-1:0] wait_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                        wait_q <= '0;
        else if (clr_i || gnt_i || !req_i)  wait_q <= '0;
        else if (wait_q < WW'(LIMIT))       wait_q <= wait_q + 1'b1;
    end

    assign starve_o = (wait_q >= WW'(LIMIT));
endmodule

module hci_core_arb_sched #(
    parameter  int unsigned NB_REQ       = 4,
    parameter  int unsigned MAX_OUT      = 4,
    parameter  int unsigned STARVE_LIMIT = 8,
    localparam int unsigned SW           = (NB_REQ > 1) ? $clog2(NB_REQ) : 1,
    localparam int unsigned CW           = $clog2(MAX_OUT + 1)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clear_i,
    input  logic [NB_REQ-1:0] req_i,
    output logic [NB_REQ-1:0] gnt_o,
    output logic              out_req_o,
    input  logic              out_gnt_i,
    output logic [SW-1:0]     sel_o,
    input  logic              out_r_valid_i,
    output logic [SW-1:0]     r_sel_o,
    output logic [NB_REQ-1:0] r_valid_o,
    output logic [CW-1:0]     outstanding_o,
    output logic              busy_o,
    output logic              err_o
);
    localparam int unsigned PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int unsigned WW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic {RUN, DRAIN} state_e;

    state_e                         state_q, state_d;
    logic   [SW-1:0]                rr_q;
    logic   [PW-1:0]                wptr_q, rptr_q;
    logic   [CW-1:0]                count_q;
    logic   [MAX_OUT-1:0][SW-1:0]   fifo_q;
    logic   [NB_REQ-1:0]            starve;
    logic   [SW-1:0]                winner;
    logic   [SW:0]                  scan;
    logic                           found, hs, pop, drain_exit;
    logic   [SW-1:0]                head;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUT - 1)) ? '0 : p + 1'b1;
    endfunction

    assign drain_exit = (state_q == DRAIN) && (count_q == '0);

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (clear_i)         state_d = DRAIN;
            DRAIN:   if (count_q == '0)   state_d = RUN;
            default:                      state_d = RUN;
        endcase
    end

    // Starving requesters win by lowest index; otherwise rotate from rr_q.
    always_comb begin
        winner = rr_q;
        found  = 1'b0;
        scan   = '0;
        for (int k = 0; k < NB_REQ; k++) begin
            if (!found && req_i[k] && starve[k]) begin
                winner = SW'(k);
                found  = 1'b1;
            end
        end
        for (int i = 0; i < NB_REQ; i++) begin
            scan = {1'b0, rr_q} + (SW+1)'(i);
            if (scan >= (SW+1)'(NB_REQ)) scan = scan - (SW+1)'(NB_REQ);
            if (!found && req_i[scan[SW-1:0]]) begin
                winner = scan[SW-1:0];
                found  = 1'b1;
            end
        end
    end

    hci_core_arb_sched_wait #(
        .LIMIT (STARVE_LIMIT),
        .WW    (WW)
    ) u_wait [NB_REQ-1:0] (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clr_i    (drain_exit),
        .req_i    (req_i),
        .gnt_i    (gnt_o),
        .starve_o (starve)
    );

    // Outputs are forced quiet while reset is held, not just after it.
    assign out_req_o = rst_ni && (state_q == RUN) && (|req_i) && (count_q < CW'(MAX_OUT));
    assign hs        = out_req_o && out_gnt_i;
    assign head      = fifo_q[rptr_q];
    assign pop       = rst_ni && out_r_valid_i && (count_q != '0);
    assign err_o     = rst_ni && out_r_valid_i && (count_q == '0);
    assign sel_o     = (|req_i) ? winner : rr_q;
    assign r_sel_o   = head;
    assign outstanding_o = count_q;
    assign busy_o    = (state_q == DRAIN) || (count_q != '0);

    always_comb begin
        gnt_o = '0;
        if (hs) gnt_o[winner] = 1'b1;
    end

    always_comb begin
        r_valid_o = '0;
        if (pop) r_valid_o[head] = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= RUN;
            rr_q    <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            fifo_q  <= '0;
        end else begin
            state_q <= state_d;
            if (hs) begin
                fifo_q[wptr_q] <= winner;
                wptr_q         <= ptr_inc(wptr_q);
            end
            if (pop) rptr_q <= ptr_inc(rptr_q);
            case ({hs, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (drain_exit)
                rr_q <= '0;
            else if (hs)
                rr_q <= (winner == SW'(NB_REQ - 1)) ? '0 : winner + 1'b1;
        end
    end
endmodule

// File: tb/tb_hci_core_arb_sched.sv
// Bench for hci_core_arb_sched: vector table, directed corner sequences and a
// randomized run compared against a queue-based reference model.

module tb_hci_core_arb_sched;
    localparam int NB  = 4;
    localparam int MO  = 4;
    localparam int LIM = 3;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          clear_i = 1'b0;
    logic [NB-1:0] req_i = '0;
    logic [NB-1:0] gnt_o;
    logic          out_req_o;
    logic          out_gnt_i = 1'b0;
    logic [1:0]    sel_o;
    logic          out_r_valid_i = 1'b0;
    logic [1:0]    r_sel_o;
    logic [NB-1:0] r_valid_o;
    logic [2:0]    outstanding_o;
    logic          busy_o;
    logic          err_o;

    always #5 clk_i = ~clk_i;

    hci_core_arb_sched #(
        .NB_REQ       (NB),
        .MAX_OUT      (MO),
        .STARVE_LIMIT (LIM)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .clear_i       (clear_i),
        .req_i         (req_i),
        .gnt_o         (gnt_o),
        .out_req_o     (out_req_o),
        .out_gnt_i     (out_gnt_i),
        .sel_o         (sel_o),
        .out_r_valid_i (out_r_valid_i),
        .r_sel_o       (r_sel_o),
        .r_valid_o     (r_valid_o),
        .outstanding_o (outstanding_o),
        .busy_o        (busy_o),
        .err_o         (err_o)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: mode flag, rotation pointer, wait ages, owner queue.
    int m_drain;
    int m_rr;
    int m_wait[NB];
    int m_q[$];

    logic          s_oreq, s_err, s_busy;
    logic [NB-1:0] s_gnt, s_rv;
    logic [1:0]    s_sel, s_rsel;
    logic [2:0]    s_out;

    typedef struct {
        logic [NB-1:0] req;
        logic          g;
        logic          rv;
        logic          eoreq;
        logic [NB-1:0] egnt;
        logic [NB-1:0] erv;
        logic          eerr;
        int            esel;
        int            eout;
    } vec_t;

    vec_t tbl[5];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic model_reset();
        m_drain = 0;
        m_rr    = 0;
        foreach (m_wait[k]) m_wait[k] = 0;
        m_q.delete();
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_ni = 1'b0; req_i = '1; out_gnt_i = 1'b1; out_r_valid_i = 1'b1; clear_i = 1'b0;
        #1;
        chk("rst_out_req", out_req_o, 0);
        chk("rst_gnt", gnt_o, 0);
        chk("rst_r_valid", r_valid_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_outstanding", outstanding_o, 0);
        chk("rst_busy", busy_o, 0);
        @(negedge clk_i);
        rst_ni = 1'b1; req_i = '0; out_gnt_i = 1'b0; out_r_valid_i = 1'b0;
        model_reset();
    endtask

    task automatic step(input logic [NB-1:0] req, input logic g, input logic rv, input logic clr);
        int  w, hs, popd, eoreq, sz;
        @(negedge clk_i);
        req_i = req; out_gnt_i = g; out_r_valid_i = rv; clear_i = clr;
        #1;
        s_oreq = out_req_o; s_err = err_o; s_busy = busy_o; s_gnt = gnt_o;
        s_rv = r_valid_o; s_sel = sel_o; s_rsel = r_sel_o; s_out = outstanding_o;

        sz = m_q.size();
        w = -1;
        for (int k = 0; k < NB; k++)
            if (w < 0 && req[k] && m_wait[k] >= LIM) w = k;
        for (int i = 0; i < NB; i++)
            if (w < 0 && req[(m_rr + i) % NB]) w = (m_rr + i) % NB;
        eoreq = (m_drain == 0 && req != 0 && sz < MO) ? 1 : 0;
        hs    = (eoreq != 0 && g) ? 1 : 0;
        popd  = (rv && sz > 0) ? 1 : 0;

        chk("out_req", s_oreq, eoreq);
        chk("gnt", s_gnt, hs ? (1 << w) : 0);
        chk("sel", s_sel, (req != 0) ? w : m_rr);
        chk("r_valid", s_rv, popd ? (1 << m_q[0]) : 0);
        if (sz > 0) chk("r_sel", s_rsel, m_q[0]);
        chk("err", s_err, (rv && sz == 0) ? 1 : 0);
        chk("outstanding", s_out, sz);
        chk("busy", s_busy, (m_drain != 0 || sz > 0) ? 1 : 0);

        @(posedge clk_i);
        if (m_drain != 0 && sz == 0) begin
            m_drain = 0;
            m_rr = 0;
            foreach (m_wait[k]) m_wait[k] = 0;
        end else begin
            for (int k = 0; k < NB; k++)
                m_wait[k] = (!req[k] || (hs != 0 && w == k)) ? 0
                          : ((m_wait[k] < LIM) ? m_wait[k] + 1 : LIM);
            if (m_drain == 0 && clr) m_drain = 1;
        end
        if (popd != 0) void'(m_q.pop_front());
        if (hs != 0) begin
            m_q.push_back(w);
            m_rr = (w + 1) % NB;
        end
    endtask

    initial begin
        tbl[0] = '{4'b0001, 1'b1, 1'b0, 1'b1, 4'b0001, 4'b0000, 1'b0, 0, 0};
        tbl[1] = '{4'b0011, 1'b1, 1'b1, 1'b1, 4'b0010, 4'b0001, 1'b0, 1, 1};
        tbl[2] = '{4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0010, 1'b0, 2, 1};
        tbl[3] = '{4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b1, 2, 0};
        tbl[4] = '{4'b1000, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0, 3, 0};

        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(tbl[i].req, tbl[i].g, tbl[i].rv, 1'b0);
            chk($sformatf("tbl%0d_out_req", i), s_oreq, tbl[i].eoreq);
            chk($sformatf("tbl%0d_gnt", i), s_gnt, tbl[i].egnt);
            chk($sformatf("tbl%0d_r_valid", i), s_rv, tbl[i].erv);
            chk($sformatf("tbl%0d_err", i), s_err, tbl[i].eerr);
            chk($sformatf("tbl%0d_sel", i), s_sel, tbl[i].esel);
            chk($sformatf("tbl%0d_outstanding", i), s_out, tbl[i].eout);
        end

        // Full request load, responses two cycles behind grants.
        do_reset();
        for (int t = 0; t < 6; t++) begin
            step(4'b1111, 1'b1, (t >= 2), 1'b0);
            chk("rr_gnt_order", s_gnt, 1 << (t % 4));
            if (t >= 2) chk("rr_rvalid_order", s_rv, 1 << ((t - 2) % 4));
        end

        // Fill to MAX_OUT, then one response reopens the port.
        do_reset();
        for (int t = 0; t < 4; t++) begin
            step(4'b1111, 1'b1, 1'b0, 1'b0);
            chk("fill_out_req", s_oreq, 1);
        end
        step(4'b1111, 1'b1, 1'b0, 1'b0);
        chk("full_out_req", s_oreq, 0);
        chk("full_outstanding", s_out, 4);
        step(4'b1111, 1'b1, 1'b1, 1'b0);
        chk("full_pop_out_req", s_oreq, 0);
        chk("full_pop_rvalid", s_rv, 4'b0001);
        step(4'b1111, 1'b1, 1'b1, 1'b0);
        chk("reopen_out_req", s_oreq, 1);
        chk("pushpop_outstanding", s_out, 3);
        chk("pushpop_r_sel", s_rsel, 1);
        step(4'b0000, 1'b0, 1'b0, 1'b0);
        chk("pushpop_after", s_out, 3);

        // Reset with entries in flight discards them; a late response is an error.
        do_reset();
        step(4'b0000, 1'b0, 1'b1, 1'b0);
        chk("orphan_err", s_err, 1);
        chk("orphan_rvalid", s_rv, 0);
        chk("orphan_outstanding", s_out, 0);
        step(4'b0000, 1'b0, 1'b0, 1'b0);
        chk("orphan_err_pulse", s_err, 0);

        // Requester 2 ages past the limit and beats index 0 at rr_q=0.
        for (int t = 0; t < 3; t++) step(4'b0100, 1'b0, 1'b0, 1'b0);
        step(4'b0101, 1'b1, 1'b0, 1'b0);
        chk("starve_gnt", s_gnt, 4'b0100);

        // Drain with two outstanding, then restart from index 0.
        step(4'b0001, 1'b1, 1'b0, 1'b0);
        chk("drain_setup_gnt", s_gnt, 4'b0001);
        step(4'b1111, 1'b0, 1'b0, 1'b1);
        chk("drain_busy0", s_busy, 1);
        step(4'b1111, 1'b1, 1'b1, 1'b0);
        chk("drain_out_req1", s_oreq, 0);
        chk("drain_gnt1", s_gnt, 0);
        chk("drain_rvalid1", s_rv, 4'b0100);
        step(4'b1111, 1'b1, 1'b1, 1'b0);
        chk("drain_out_req2", s_oreq, 0);
        chk("drain_rvalid2", s_rv, 4'b0001);
        step(4'b1111, 1'b1, 1'b0, 1'b0);
        chk("drain_out_req3", s_oreq, 0);
        chk("drain_busy3", s_busy, 1);
        step(4'b1001, 1'b1, 1'b0, 1'b0);
        chk("drain_restart_gnt", s_gnt, 4'b0001);
        chk("drain_restart_busy", s_busy, 0);

        // Randomized traffic against the model.
        do_reset();
        for (int t = 0; t < 400; t++)
            step(NB'($urandom), ($urandom % 4) != 0, ($urandom % 3) == 0, ($urandom % 40) == 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
